simple_uart_rx: RTL and testbench

//  UART receiver; downstream peer of the UART transmitter, consuming a serial line of the same format (LSB first).

---
 rtl/simple_uart_rx_pkg.sv | 21 ++
 rtl/simple_uart_rx_sync.sv | 23 ++
 rtl/simple_uart_rx.sv | 219 +++++++++++++++++++++
 tb/tb_simple_uart_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and
// bit-counter helpers.
package simple_uart_rx_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Bit counter covers up to 9 data bits or 2 stop bits
  localparam int BIT_CNT_W = 4;

  // Terminal value of the bit counter for a run of n bits
  function automatic logic [BIT_CNT_W-1:0] bit_last(input int n);
    return BIT_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/simple_uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line. Both flops come
// out of reset at 1 so an idle line never looks like a falling edge.
module simple_uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input, preset to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/simple_uart_rx.sv
// UART receiver: oversamples rxd at clk, qualifies the start bit at its
// centre, samples each data/stop bit at its centre (LSB first), and hands
// good bytes to a valid/ready holding register. Framing errors and overruns
// are reported as single-cycle pulses.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RX_IDLE  | waiting for a 1->0 edge on the synchronised line
// RX_START | half-period wait, then confirm start bit is still low
// RX_DATA  | one full period per data bit, shift sample in LSB first
// RX_STOP  | one full period per stop bit, any low sample marks an error
module simple_uart_rx
  import simple_uart_rx_pkg::*;
#(
  parameter int BITS_DATA    = 8,
  parameter int STOP_BITS    = 1,
  parameter int COUNTER_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COUNTER_BITS-1:0] cfg_counter_div,
  input  logic                    rxd,
  output logic [BITS_DATA-1:0]    axis_data,
  output logic                    axis_valid,
  input  logic                    axis_ready,
  output logic                    frame_err,
  output logic                    overrun
);

  logic                    rxd_s;
  logic                    rxd_q;
  logic                    start_edge;

  rx_state_e               state_q;
  rx_state_e               state_d;

  logic [COUNTER_BITS-1:0] cnt_q;
  logic [COUNTER_BITS-1:0] div_q;
  logic                    cnt_done;

  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic                    last_data;
  logic                    last_stop;

  logic [BITS_DATA-1:0]    shift_q;
  logic                    err_q;

  logic                    load_half;
  logic                    load_full;
  logic                    shift_en;
  logic                    stop_smp;
  logic                    frame_end;
  logic                    frame_bad;
  logic                    handshake;

  simple_uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // Previous synchronised level, used to find the start edge. A line held
  // low (break) produces no new edge until it has gone high again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_q <= 1'b1;
    end else begin
      rxd_q <= rxd_s;
    end
  end

  assign start_edge = rxd_q & ~rxd_s;
  assign cnt_done   = (cnt_q == '0);
  assign last_data  = (bit_cnt_q == bit_last(BITS_DATA));
  assign last_stop  = (bit_cnt_q == bit_last(STOP_BITS));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d   = state_q;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    stop_smp  = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (start_edge) begin
          state_d   = RX_START;
          load_half = 1'b1;
        end
      end
      RX_START: begin
        if (cnt_done) begin
          if (rxd_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            load_full = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (cnt_done) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (last_data) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (cnt_done) begin
          stop_smp  = 1'b1;
          load_full = 1'b1;
          if (last_stop) begin
            state_d   = RX_IDLE;
            frame_end = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Bit-period down-counter; the divider is captured at the start edge so
  // reprogramming mid-frame cannot disturb the frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (load_half) begin
      cnt_q <= cfg_counter_div >> 1;
      div_q <= cfg_counter_div;
    end else if (load_full) begin
      cnt_q <= div_q;
    end else if (!cnt_done) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Bit counter, shared between the data phase and the stop phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
    end else if (load_half) begin
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      bit_cnt_q <= last_data ? '0 : bit_cnt_q + 1'b1;
    end else if (stop_smp) begin
      bit_cnt_q <= last_stop ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // Data shift register, LSB arrives first so new bits enter at the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (shift_en) begin
      if (BITS_DATA > 1) begin
        shift_q <= {rxd_s, shift_q[BITS_DATA-1:1]};
      end else begin
        shift_q <= rxd_s;
      end
    end
  end

  // Sticky stop-bit error for the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (load_half) begin
      err_q <= 1'b0;
    end else if (stop_smp && !rxd_s) begin
      err_q <= 1'b1;
    end
  end

  // The final stop sample is folded in directly so the verdict is ready in
  // the same cycle the frame ends
  assign frame_bad = err_q | ~rxd_s;
  assign handshake = axis_valid & axis_ready;

  // Holding register and single-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axis_data  <= '0;
      axis_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (handshake) begin
        axis_valid <= 1'b0;
      end
      if (frame_end) begin
        if (frame_bad) begin
          frame_err <= 1'b1;
        end else if (!axis_valid || axis_ready) begin
          axis_data  <= shift_q;
          axis_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_uart_rx.sv
// Directed bench for simple_uart_rx. A transaction-level model predicts,
// per frame sent, whether a byte, a framing error or an overrun must appear;
// a single compare process checks the DUT against that prediction on every
// cycle.
module tb_simple_uart_rx;

  localparam int BITS  = 8;
  localparam int STOPS = 1;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cfg = 16'd15;
  logic          rxd = 1'b1;
  logic [7:0]    axis_data;
  logic          axis_valid;
  logic          axis_ready = 1'b0;
  logic          frame_err;
  logic          overrun;

  simple_uart_rx #(
    .BITS_DATA    (BITS),
    .STOP_BITS    (STOPS),
    .COUNTER_BITS (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_counter_div (cfg),
    .rxd             (rxd),
    .axis_data       (axis_data),
    .axis_valid      (axis_valid),
    .axis_ready      (axis_ready),
    .frame_err       (frame_err),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Model state
  logic [7:0] exp_q[$];
  logic [7:0] acc_log[$];
  int         err_pending = 0;
  int         ovr_pending = 0;
  int         err_seen    = 0;
  int         ovr_seen    = 0;
  int         rise_cyc    = -1;
  logic       prev_valid  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predict the outcome of one complete frame
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) err_pending++;
    else if (!axis_ready && exp_q.size() > 0) ovr_pending++;
    else exp_q.push_back(b);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive the first nbits bits of a frame, each held for div+1 clocks
  task automatic send_frame(input logic [7:0] b, input int div, input bit stop_ok, input int nbits);
    logic v;
    cfg = CW'(div);
    for (int i = 0; i < 1 + BITS + STOPS; i++) begin
      if (i >= nbits) break;
      if (i == 0) v = 1'b0;
      else if (i <= BITS) v = b[i-1];
      else v = stop_ok;
      rxd = v;
      tick(div + 1);
    end
    if (nbits >= 1 + BITS + STOPS) rxd = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pending_bytes"}, exp_q.size(), 0);
    check({tag, "_pending_err"}, err_pending, 0);
    check({tag, "_pending_ovr"}, ovr_pending, 0);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (axis_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got data %02h expected no byte", axis_data);
        end else begin
          check("axis_data", {24'd0, axis_data}, {24'd0, exp_q[0]});
        end
        if (axis_ready) begin
          acc_log.push_back(axis_data);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (axis_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
      if (frame_err) begin
        err_seen++;
        checks++;
        if (err_pending == 0) begin
          failures++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else err_pending--;
      end
      if (overrun) begin
        ovr_seen++;
        checks++;
        if (ovr_pending == 0) begin
          failures++;
          $display("FAIL unexpected_overrun: got 1 expected 0");
        end else ovr_pending--;
      end
      prev_valid = axis_valid;
    end
  end

  int t_start;

  initial begin
    // Reset values
    tick(3);
    check("rst_valid", axis_valid, 0);
    check("rst_data", axis_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick(5);

    // Two frames at div=15 with ready high
    axis_ready = 1'b1;
    acc_log.delete();
    rise_cyc = -1;
    t_start = cyc;
    model_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 15, 1'b1, 10);
    model_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 15, 1'b1, 10);
    tick(40);
    check("t1_latency", rise_cyc - t_start, 155);
    check("t1_count", acc_log.size(), 2);
    check("t1_byte0", acc_log[0], 8'hA5);
    check("t1_byte1", acc_log[1], 8'h3C);
    check_idle("t1");

    // Short low glitch is ignored, following frame intact
    acc_log.delete();
    err_seen = 0;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    check("t2_glitch_valid", axis_valid, 0);
    model_frame(8'h55, 1'b1);
    send_frame(8'h55, 15, 1'b1, 10);
    tick(40);
    check("t2_count", acc_log.size(), 1);
    check("t2_byte", acc_log[0], 8'h55);
    check("t2_err_seen", err_seen, 0);
    check_idle("t2");

    // Stop bit forced low
    acc_log.delete();
    err_seen = 0;
    model_frame(8'h81, 1'b0);
    send_frame(8'h81, 15, 1'b0, 10);
    rxd = 1'b1;
    tick(40);
    check("t3_err_seen", err_seen, 1);
    check("t3_count", acc_log.size(), 0);
    check("t3_valid", axis_valid, 0);
    check_idle("t3");

    // Overrun with consumer stalled
    axis_ready = 1'b0;
    acc_log.delete();
    ovr_seen = 0;
    model_frame(8'h11, 1'b1);
    send_frame(8'h11, 15, 1'b1, 10);
    model_frame(8'h22, 1'b1);
    send_frame(8'h22, 15, 1'b1, 10);
    tick(40);
    check("t4_valid_held", axis_valid, 1);
    check("t4_data_held", axis_data, 8'h11);
    check("t4_ovr_seen", ovr_seen, 1);
    check("t4_count_stalled", acc_log.size(), 0);
    axis_ready = 1'b1;
    tick(5);
    check("t4_count", acc_log.size(), 1);
    check("t4_byte", acc_log[0], 8'h11);
    check("t4_valid_after", axis_valid, 0);
    check_idle("t4");

    // Back-to-back at the minimum divider
    acc_log.delete();
    err_seen = 0;
    ovr_seen = 0;
    model_frame(8'h00, 1'b1);
    send_frame(8'h00, 3, 1'b1, 10);
    model_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 3, 1'b1, 10);
    tick(40);
    check("t5_count", acc_log.size(), 2);
    check("t5_byte0", acc_log[0], 8'h00);
    check("t5_byte1", acc_log[1], 8'hFF);
    check("t5_err_seen", err_seen, 0);
    check("t5_ovr_seen", ovr_seen, 0);
    check_idle("t5");

    // Reset in the middle of a frame, with a byte still held
    axis_ready = 1'b0;
    acc_log.delete();
    model_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 15, 1'b1, 10);
    tick(20);
    check("t6_held_before", axis_valid, 1);
    send_frame(8'h96, 15, 1'b1, 5);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", axis_valid, 0);
    check("t6_rst_data", axis_data, 0);
    check("t6_rst_frame_err", frame_err, 0);
    check("t6_rst_overrun", overrun, 0);
    exp_q.delete();
    rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    axis_ready = 1'b1;
    err_seen = 0;
    ovr_seen = 0;
    model_frame(8'h69, 1'b1);
    send_frame(8'h69, 15, 1'b1, 10);
    tick(40);
    check("t6_count", acc_log.size(), 1);
    check("t6_byte", acc_log[0], 8'h69);
    check("t6_err_seen", err_seen, 0);
    check("t6_ovr_seen", ovr_seen, 0);
    check_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
